// File: rtl/onehot_key_capture_if.sv
// Key-capture bus: raw button levels in, registered one-hot code and strobes out.
interface onehot_key_capture_if;
  logic [3:0] key_raw;
  logic [3:0] onehot;
  logic       valid;
  logic       pending_any;

  modport master (
    output key_raw,
    input  onehot,
    input  valid,
    input  pending_any
  );

  modport slave (
    input  key_raw,
    output onehot,
    output valid,
    output pending_any
  );
endinterface

// File: rtl/onehot_key_capture.sv
// Four-key synchronise/debounce/press capture with priority-serialised
// one-hot issue; onehot is always a legal single-bit code.
module onehot_key_capture #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  onehot_key_capture_if.slave  bus
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [3:0]    s1_q, s1_d;
  logic [3:0]    s2_q, s2_d;
  logic [3:0]    stable_q, stable_d;
  logic [3:0]    pending_q, pending_d;
  logic [3:0]    onehot_q, onehot_d;
  logic          valid_q, valid_d;
  logic [CW-1:0] cnt_q [4];
  logic [CW-1:0] cnt_d [4];
  logic [3:0]    press;
  logic [3:0]    issue;

  always_comb begin
    s1_d     = bus.key_raw;
    s2_d     = s1_q;
    stable_d = stable_q;
    press    = '0;
    for (int k = 0; k < 4; k++) begin
      cnt_d[k] = '0;
      if (s2_q[k] != stable_q[k]) begin
        if (cnt_q[k] == CNT_MAX) begin
          stable_d[k] = s2_q[k];
          press[k]    = s2_q[k];
        end else begin
          cnt_d[k] = cnt_q[k] + CW'(1);
        end
      end
    end
    // Lowest set pending bit; a fresh press on the same key wins the clear.
    issue     = pending_q & (~pending_q + 4'd1);
    pending_d = (pending_q & ~issue) | press;
    valid_d   = |pending_q;
    onehot_d  = valid_d ? issue : onehot_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q      <= '0;
      s2_q      <= '0;
      stable_q  <= '0;
      pending_q <= '0;
      onehot_q  <= 4'b0001;
      valid_q   <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      stable_q  <= stable_d;
      pending_q <= pending_d;
      onehot_q  <= onehot_d;
      valid_q   <= valid_d;
      for (int k = 0; k < 4; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  assign bus.onehot      = onehot_q;
  assign bus.valid       = valid_q;
  assign bus.pending_any = |pending_q;

endmodule

// File: tb/tb_onehot_key_capture.sv
// Scoreboard bench: stimulus queues expected pulses, monitor pops and checks.
module tb_onehot_key_capture;

  logic clk = 1'b0;
  logic rst_n;
  int   edge_n = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  logic started = 1'b0;
  logic [3:0] last_oh = 4'b0001;

  typedef struct {
    logic [3:0] oh;
    logic       pa;
    int         at;
  } exp_t;

  exp_t sb[$];

  onehot_key_capture_if bus ();

  onehot_key_capture #(.DEBOUNCE_CYCLES(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [3:0] oh, input logic pa, input int dt);
    exp_t e;
    e.oh = oh;
    e.pa = pa;
    e.at = edge_n + dt;
    sb.push_back(e);
  endtask

  // Monitor: sample 1 time unit after each rising edge.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      started = 1'b1;
      n_vec++;
      if (bus.onehot !== 4'b0001 || bus.valid !== 1'b0 ||
          bus.pending_any !== 1'b0) begin
        n_bad++;
        $display("FAIL reset edge %0d: got oh=%b v=%b pa=%b want 0001/0/0",
                 edge_n, bus.onehot, bus.valid, bus.pending_any);
      end
      last_oh = 4'b0001;
    end else if (started) begin
      if (bus.valid === 1'b1) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL spurious_valid edge %0d: got oh=%b want no pulse",
                   edge_n, bus.onehot);
        end else begin
          e = sb.pop_front();
          if (bus.onehot !== e.oh || bus.pending_any !== e.pa ||
              edge_n != e.at) begin
            n_bad++;
            $display("FAIL pulse: got oh=%b pa=%b edge=%0d want oh=%b pa=%b edge=%0d",
                     bus.onehot, bus.pending_any, edge_n, e.oh, e.pa, e.at);
          end
          last_oh = e.oh;
        end
      end else begin
        n_vec++;
        if (bus.onehot !== last_oh || bus.valid !== 1'b0) begin
          n_bad++;
          $display("FAIL hold edge %0d: got oh=%b v=%b want oh=%b v=0",
                   edge_n, bus.onehot, bus.valid, last_oh);
        end
        if (sb.size() > 0 && sb[0].at < edge_n) begin
          e = sb.pop_front();
          n_vec++;
          n_bad++;
          $display("FAIL missing_pulse: got none by edge %0d want oh=%b at %0d",
                   edge_n, e.oh, e.at);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    bus.key_raw = 4'b1111;
    wait_n(3);
    rst_n = 1'b1;
    push(4'b0001, 1'b1, 19);
    push(4'b0010, 1'b1, 20);
    push(4'b0100, 1'b1, 21);
    push(4'b1000, 1'b0, 22);
    wait_n(30);
    bus.key_raw = 4'b0000;
    wait_n(40);

    bus.key_raw = 4'b0100;
    push(4'b0100, 1'b0, 19);
    wait_n(40);
    bus.key_raw = 4'b0000;
    wait_n(40);

    bus.key_raw = 4'b0010;
    wait_n(15);
    bus.key_raw = 4'b0000;
    wait_n(40);
    bus.key_raw = 4'b0010;
    push(4'b0010, 1'b0, 19);
    wait_n(16);
    bus.key_raw = 4'b0000;
    wait_n(40);

    for (int i = 0; i < 12; i++) begin
      bus.key_raw = (i % 2 == 0) ? 4'b1000 : 4'b0000;
      wait_n(5);
    end
    bus.key_raw = 4'b1000;
    push(4'b1000, 1'b0, 19);
    wait_n(40);
    bus.key_raw = 4'b0000;
    wait_n(40);

    bus.key_raw = 4'b1001;
    push(4'b0001, 1'b1, 19);
    push(4'b1000, 1'b0, 20);
    wait_n(40);
    bus.key_raw = 4'b0000;
    wait_n(40);

    // Key 0 pending lands on the same edge key 1 counter reaches 10.
    bus.key_raw = 4'b0001;
    wait_n(6);
    bus.key_raw = 4'b0011;
    wait_n(12);
    rst_n = 1'b0;
    wait_n(2);
    rst_n = 1'b1;
    push(4'b0001, 1'b1, 19);
    push(4'b0010, 1'b0, 20);
    wait_n(40);
    bus.key_raw = 4'b0000;
    wait_n(40);

    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d outstanding want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
